// File: rtl/latency_event_encoder.sv
// Time-to-first-spike encoder: walks a latency window and drives the 42-line event bus,
// holding each event until acknowledged. Optional macro WTA_STOP_EN aborts a frame on any spike.
module latency_event_encoder #(
  parameter int unsigned p_lat_width   = 4,
  parameter int unsigned p_gap         = 2,
  parameter int unsigned p_ack_timeout = 16,
  parameter int unsigned p_n           = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_frame_valid,
  output logic                      o_frame_ready,
  input  logic [42*p_lat_width-1:0] i_latency,
  input  logic [42:1]               i_sync,
  input  logic [p_n:1]              i_spike,
  output logic [42:1]               o_event,
  output logic [p_lat_width-1:0]    o_timestep,
  output logic                      o_frame_done,
  output logic                      o_ack_err
);

  localparam int unsigned NumSyn   = 42;
  localparam int unsigned TMax     = (1 << p_lat_width) - 1;
  localparam int unsigned TimerW   = (p_ack_timeout > 1) ? $clog2(p_ack_timeout) : 1;
  localparam int unsigned GapW     = (p_gap > 1) ? $clog2(p_gap) : 1;
  localparam int unsigned GapLastI = (p_gap == 0) ? 0 : p_gap - 1;

  localparam logic [p_lat_width-1:0] TLast     = p_lat_width'(TMax - 1);
  localparam logic [TimerW-1:0]      TimerLast = TimerW'(p_ack_timeout - 1);
  localparam logic [GapW-1:0]        GapLast   = GapW'(GapLastI);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StAck,
    StGap,
    StDone
  } state_e;

  state_e                          state_q, state_d;
  logic [NumSyn*p_lat_width-1:0]   lat_q, lat_d;
  logic [p_lat_width-1:0]          t_q, t_d;
  logic [NumSyn:1]                 pending_q, pending_d;
  logic [TimerW-1:0]               timer_q, timer_d;
  logic [GapW-1:0]                 gap_q, gap_d;
  logic                            err_q, err_d;

  logic [NumSyn:1] mask;
  logic [NumSyn:1] remaining;
  logic            advance;
  logic            to_gap;

  always_comb begin
    mask = '0;
    for (int s = 1; s <= NumSyn; s++) begin
      mask[s] = (lat_q[(s-1)*p_lat_width +: p_lat_width] == t_q);
    end
  end

  assign remaining = pending_q & ~i_sync;

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    t_d       = t_q;
    pending_d = pending_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    err_d     = err_q;
    advance   = 1'b0;
    to_gap    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_frame_valid) begin
          lat_d   = i_latency;
          t_d     = '0;
          err_d   = 1'b0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (mask != '0) begin
          pending_d = mask;
          timer_d   = '0;
          state_d   = StAck;
        end else begin
          advance = 1'b1;
        end
      end
      StAck: begin
        // A clearing sync takes priority over a simultaneous timeout.
        if (remaining == '0) begin
          pending_d = '0;
          to_gap    = 1'b1;
        end else if (timer_q == TimerLast) begin
          pending_d = '0;
          err_d     = 1'b1;
          to_gap    = 1'b1;
        end else begin
          pending_d = remaining;
          timer_d   = timer_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          advance = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (to_gap) begin
      if (p_gap == 0) begin
        advance = 1'b1;
      end else begin
        gap_d   = '0;
        state_d = StGap;
      end
    end

    if (advance) begin
      if (t_q == TLast) begin
        state_d = StDone;
      end else begin
        t_d     = t_q + 1'b1;
        state_d = StScan;
      end
    end

`ifdef WTA_STOP_EN
    if ((|i_spike) && (state_q inside {StScan, StAck, StGap})) begin
      pending_d = '0;
      state_d   = StDone;
    end
`endif
  end

`ifndef WTA_STOP_EN
  logic unused_spike;
  assign unused_spike = ^i_spike;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      lat_q     <= '0;
      t_q       <= '0;
      pending_q <= '0;
      timer_q   <= '0;
      gap_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      t_q       <= t_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      err_q     <= err_d;
    end
  end

  assign o_event       = pending_q;
  assign o_timestep    = t_q;
  assign o_frame_done  = (state_q == StDone);
  assign o_frame_ready = (state_q == StIdle);
  assign o_ack_err     = err_q;

endmodule
